// File: rtl/mycpu_ctrl_if.sv
// Instruction-memory fetch bus between mycpu_ctrl and imem.
// The word is accepted on the edge where imem_req and imem_valid are both high.
interface mycpu_ctrl_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/mycpu_ctrl.sv
// mycpu multi-cycle control sequencer.
// Fetches, decodes and sequences register-file/fu control; owns PC and Z/N flags.
module mycpu_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic         clk,
  input  logic         rst,
  mycpu_ctrl_if.master imem,
  output logic [3:0]   fs_out,
  output logic [2:0]   sa_out,
  output logic [2:0]   sb_out,
  output logic [2:0]   dr_out,
  output logic         rf_we_out,
  input  logic         z_in,
  input  logic         n_in,
  output logic         z_flag_out,
  output logic         n_flag_out
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB
  } state_t;

  localparam logic [3:0] OP_BRZ = 4'd14;
  localparam logic [3:0] OP_JMP = 4'd15;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] ir;
  logic        req_q;

  logic [3:0]  op;
  logic        is_branch;
  logic [15:0] off9;
  logic [15:0] off12;

  assign op        = ir[15:12];
  assign is_branch = (op == OP_BRZ) || (op == OP_JMP);
  assign off9      = {{7{ir[8]}}, ir[8:0]};
  assign off12     = {{4{ir[11]}}, ir[11:0]};

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ir         <= 16'h0000;
      req_q      <= 1'b0;
      fs_out     <= 4'd0;
      sa_out     <= 3'd0;
      sb_out     <= 3'd0;
      dr_out     <= 3'd0;
      rf_we_out  <= 1'b0;
      z_flag_out <= 1'b0;
      n_flag_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= FETCH;
          req_q <= 1'b1;
        end
        FETCH: begin
          if (imem.imem_valid) begin
            ir    <= imem.imem_rdata;
            pc    <= pc + 16'd1;
            req_q <= 1'b0;
            state <= DECODE;
          end
        end
        DECODE: begin
          fs_out <= ir[15:12];
          dr_out <= ir[11:9];
          sa_out <= ir[8:6];
          sb_out <= ir[5:3];
          state  <= EXEC;
        end
        EXEC: begin
          // pc already points past the branch word
          if (is_branch) begin
            if (op == OP_JMP)
              pc <= pc + off12;
            else if (z_flag_out)
              pc <= pc + off9;
            req_q <= 1'b1;
            state <= FETCH;
          end else begin
            z_flag_out <= z_in;
            n_flag_out <= n_in;
            rf_we_out  <= 1'b1;
            state      <= WB;
          end
        end
        WB: begin
          rf_we_out <= 1'b0;
          req_q     <= 1'b1;
          state     <= FETCH;
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mycpu_ctrl.sv
// Scoreboard bench for mycpu_ctrl: stimulus queues expected fetches/writes,
// a negedge monitor checks them as the DUT presents them.
module tb_mycpu_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] fs_out;
  logic [2:0] sa_out;
  logic [2:0] sb_out;
  logic [2:0] dr_out;
  logic       rf_we_out;
  logic       z_in = 1'b0;
  logic       n_in = 1'b0;
  logic       z_flag_out;
  logic       n_flag_out;

  mycpu_ctrl_if bus ();

  mycpu_ctrl #(.RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem       (bus.master),
    .fs_out     (fs_out),
    .sa_out     (sa_out),
    .sb_out     (sb_out),
    .dr_out     (dr_out),
    .rf_we_out  (rf_we_out),
    .z_in       (z_in),
    .n_in       (n_in),
    .z_flag_out (z_flag_out),
    .n_flag_out (n_flag_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] fetch_q[$];
  logic [14:0] wr_q[$];
  int          cyc = 0;
  int          acc_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (bus.imem_req && bus.imem_valid) begin
        if (fetch_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fetch_unexpected addr=%0h", bus.imem_addr);
        end else begin
          chk("fetch_addr", {16'h0, bus.imem_addr},
              {16'h0, fetch_q.pop_front()});
        end
        acc_cyc = cyc;
      end
      if (rf_we_out) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL we_unexpected fs=%0h dr=%0h", fs_out, dr_out);
        end else begin
          chk("wb_fields",
              {17'h0, fs_out, dr_out, sa_out, sb_out,
               z_flag_out, n_flag_out},
              {17'h0, wr_q.pop_front()});
        end
        chk("we_latency", cyc - acc_cyc, 3);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req;
    int n;
    n = 0;
    while (!bus.imem_req && n < 20) begin
      step();
      n++;
    end
    if (!bus.imem_req) chk("req_timeout", 0, 1);
  endtask

  task automatic fetch(input logic [15:0] exp_addr, input logic [15:0] word,
                       input int waits, input logic z, input logic n,
                       input logic alu);
    wait_req();
    z_in = z;
    n_in = n;
    for (int i = 0; i < waits; i++) begin
      bus.imem_valid = 1'b0;
      step();
      chk("stall_req", {31'h0, bus.imem_req}, 1);
      chk("stall_addr", {16'h0, bus.imem_addr}, {16'h0, exp_addr});
      chk("stall_we", {31'h0, rf_we_out}, 0);
    end
    fetch_q.push_back(exp_addr);
    if (alu)
      wr_q.push_back({word[15:12], word[11:9], word[8:6], word[5:3], z, n});
    bus.imem_valid = 1'b1;
    bus.imem_rdata = word;
    step();
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 16'hDEAD;
  endtask

  task automatic check_reset_outputs;
    chk("rst_req", {31'h0, bus.imem_req}, 0);
    chk("rst_addr", {16'h0, bus.imem_addr}, 0);
    chk("rst_we", {31'h0, rf_we_out}, 0);
    chk("rst_flags", {30'h0, z_flag_out, n_flag_out}, 0);
  endtask

  task automatic release_and_check;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("restart_c1_req", {31'h0, bus.imem_req}, 0);
    @(negedge clk);
    chk("restart_c2_req", {31'h0, bus.imem_req}, 1);
    chk("restart_c2_addr", {16'h0, bus.imem_addr}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 16'h0000;
    rst = 1'b1;
    repeat (3) step();
    check_reset_outputs();
    chk("rst_fs", {28'h0, fs_out}, 0);
    chk("rst_dr", {29'h0, dr_out}, 0);
    release_and_check();

    fetch(16'h0000, 16'h3298, 0, 1'b0, 1'b0, 1'b1);
    fetch(16'h0001, 16'h8BB8, 3, 1'b0, 1'b1, 1'b1);
    fetch(16'h0002, 16'hDE08, 0, 1'b1, 1'b1, 1'b1);
    fetch(16'h0003, 16'h0500, 1, 1'b0, 1'b0, 1'b1);
    fetch(16'h0004, 16'h4650, 0, 1'b1, 1'b0, 1'b1);
    fetch(16'h0005, 16'hE1FE, 0, 1'b0, 1'b0, 1'b0);
    fetch(16'h0004, 16'h4650, 0, 1'b0, 1'b1, 1'b1);
    fetch(16'h0005, 16'hE1FE, 0, 1'b1, 1'b0, 1'b0);
    fetch(16'h0006, 16'hFFF8, 0, 1'b1, 1'b0, 1'b0);
    fetch(16'hFFFF, 16'hF001, 2, 1'b1, 1'b0, 1'b0);
    wait_req();
    chk("jmp_flags", {30'h0, z_flag_out, n_flag_out}, 32'h1);

    // reset during the write-back pulse
    fetch(16'h0001, 16'h3298, 0, 1'b1, 1'b1, 1'b1);
    n = 0;
    @(negedge clk);
    while (!rf_we_out && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("wb_seen", {31'h0, rf_we_out}, 1);
    chk("wb_flags", {30'h0, z_flag_out, n_flag_out}, 32'h3);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (3) step();
    release_and_check();

    // reset held 3 cycles in the middle of a stalled fetch
    bus.imem_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (3) step();
    release_and_check();

    fetch(16'h0000, 16'h1240, 0, 1'b0, 1'b1, 1'b1);
    wait_req();
    chk("final_addr", {16'h0, bus.imem_addr}, 32'h1);
    repeat (3) step();
    chk("fetch_q_empty", fetch_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
